// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU memory responder: FSM state encoding,
// wait-counter width and the out-of-range address check.
package cpu_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        DATA,
        RELEASE,
        FAULT
    } state_t;

    localparam int WAIT_W = 4;

    // Any set bit above the word-index field makes the byte address unreachable.
    function automatic logic out_of_range(input logic [31:0] addr, input int addr_w);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (addr_w + 2);
        return |(addr & mask);
    endfunction

endpackage

// File: rtl/cpu_mem_array.sv
// Single-port synchronous word RAM with registered (read-first) output.
module cpu_mem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Wait-state memory responder pacing the CPU through clk_en, one fetch plus at
// most one data access per step. Define CPU_MEM_LOAD_EN to add the IDLE-time load port.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [31:0] instruction_memory_a,
    input  logic        instruction_memory_en,
    input  logic [31:0] data_memory_a,
    input  logic [31:0] data_memory_out_v,
    input  logic        data_memory_read,
    input  logic        data_memory_write,
`ifdef CPU_MEM_LOAD_EN
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_a,
    input  logic [31:0]       load_v,
`endif
    output logic [31:0] instruction_memory_v,
    output logic [31:0] data_memory_in_v,
    output logic        clk_en,
    output logic        mem_fault
);

    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT);

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                fetch_oor, is_read, is_write;
    logic [ADDR_W-1:0]   fetch_idx, data_idx;
    logic [31:0]         store_v;
    logic                ld_fetch, ld_data, upd_instr, upd_load;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [31:0]         ram_wdata, ram_rdata;

    cpu_mem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // The RAM address tracks the address that will be consumed next, so the
    // registered read data is already valid when the wait counter expires.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ram_we       = 1'b0;
        ram_addr     = fetch_idx;
        ram_wdata    = store_v;
        ld_fetch     = 1'b0;
        ld_data      = 1'b0;
        upd_instr    = 1'b0;
        upd_load     = 1'b0;
        case (state)
            IDLE: begin
                ram_addr = instruction_memory_a[ADDR_W+1:2];
`ifdef CPU_MEM_LOAD_EN
                if (load_en) begin
                    ram_we    = 1'b1;
                    ram_addr  = load_a;
                    ram_wdata = load_v;
                end else
`endif
                if (instruction_memory_en) begin
                    state_nxt    = FETCH;
                    wait_cnt_nxt = WAIT_LD;
                    ld_fetch     = 1'b1;
                end
            end
            FETCH: begin
                if (wait_cnt == '0) begin
                    if (fetch_oor) begin
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = DECODE;
                        upd_instr = 1'b1;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                end
            end
            DECODE: begin
                ram_addr = data_memory_a[ADDR_W+1:2];
                ld_data  = 1'b1;
                if (data_memory_read && data_memory_write) begin
                    state_nxt = FAULT;
                end else if (data_memory_read || data_memory_write) begin
                    if (out_of_range(data_memory_a, ADDR_W)) begin
                        state_nxt = FAULT;
                    end else begin
                        state_nxt    = DATA;
                        wait_cnt_nxt = WAIT_LD;
                    end
                end else begin
                    state_nxt = RELEASE;
                end
            end
            DATA: begin
                ram_addr = data_idx;
                if (wait_cnt == '0) begin
                    ram_we    = is_write;
                    upd_load  = is_read;
                    state_nxt = RELEASE;
                end else begin
                    wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                end
            end
            RELEASE: state_nxt = IDLE;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state                <= IDLE;
            wait_cnt             <= '0;
            fetch_oor            <= 1'b0;
            is_read              <= 1'b0;
            is_write             <= 1'b0;
            instruction_memory_v <= '0;
            data_memory_in_v     <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (ld_fetch) begin
                fetch_oor <= out_of_range(instruction_memory_a, ADDR_W);
            end
            if (ld_data) begin
                is_read  <= data_memory_read;
                is_write <= data_memory_write;
            end
            if (upd_instr) begin
                instruction_memory_v <= ram_rdata;
            end
            if (upd_load) begin
                data_memory_in_v <= ram_rdata;
            end
        end
    end

    // Address/data latches carry no control meaning, so they are not reset.
    always_ff @(posedge clk) begin
        if (ld_fetch) begin
            fetch_idx <= instruction_memory_a[ADDR_W+1:2];
        end
        if (ld_data) begin
            data_idx <= data_memory_a[ADDR_W+1:2];
            store_v  <= data_memory_out_v;
        end
    end

    assign clk_en    = (state == RELEASE);
    assign mem_fault = (state == FAULT);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: WAIT=1 instance (a) and WAIT=0 instance (b).
module tb_cpu_mem_responder;

    typedef struct {
        bit          chk_i;
        logic [31:0] instr;
        logic [31:0] data;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    exp_t qa[$];
    exp_t qb[$];
    int gap_a = 0;
    int gap_b = 0;

    logic        nreset_a, ien_a, rd_a, wr_a, ce_a, mf_a;
    logic [31:0] ia_a, da_a, dv_a, iv_a, dinv_a;
    logic        nreset_b, ien_b, rd_b, wr_b, ce_b, mf_b;
    logic [31:0] ia_b, da_b, dv_b, iv_b, dinv_b;

    cpu_mem_responder #(.ADDR_W(10), .WAIT(1)) dut_a (
        .clk(clk), .nreset(nreset_a),
        .instruction_memory_a(ia_a), .instruction_memory_en(ien_a),
        .data_memory_a(da_a), .data_memory_out_v(dv_a),
        .data_memory_read(rd_a), .data_memory_write(wr_a),
        .instruction_memory_v(iv_a), .data_memory_in_v(dinv_a),
        .clk_en(ce_a), .mem_fault(mf_a)
    );

    cpu_mem_responder #(.ADDR_W(10), .WAIT(0)) dut_b (
        .clk(clk), .nreset(nreset_b),
        .instruction_memory_a(ia_b), .instruction_memory_en(ien_b),
        .data_memory_a(da_b), .data_memory_out_v(dv_b),
        .data_memory_read(rd_b), .data_memory_write(wr_b),
        .instruction_memory_v(iv_b), .data_memory_in_v(dinv_b),
        .clk_en(ce_b), .mem_fault(mf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input bit b, input logic [31:0] fa, da, dv, input logic rd, wr);
        if (b) begin
            ia_b = fa; da_b = da; dv_b = dv; rd_b = rd; wr_b = wr; ien_b = 1'b1;
        end else begin
            ia_a = fa; da_a = da; dv_a = dv; rd_a = rd; wr_a = wr; ien_a = 1'b1;
        end
    endtask

    task automatic push_exp(input bit b, input bit ci, input logic [31:0] i, d, input int g);
        exp_t e;
        e.chk_i = ci; e.instr = i; e.data = d; e.gap = g;
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    // Returns at posedge+1 in the IDLE cycle following the step's clk_en pulse.
    task automatic wait_step(input bit b);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if ((b ? ce_b : ce_a) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_step_timeout actual=no_clk_en required=clk_en", b ? "b" : "a");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_instr"},  iv_a,   32'h0);
        chk({tag, "_data"},   dinv_a, 32'h0);
        chk({tag, "_clk_en"}, {31'h0, ce_a}, 32'h0);
        chk({tag, "_fault"},  {31'h0, mf_a}, 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!nreset_a) begin
            gap_a = 0;
        end else begin
            gap_a++;
            if (ce_a) begin
                if (qa.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL a_unexpected_clk_en actual=1 required=0");
                end else begin
                    e = qa.pop_front();
                    chk("a_step_cycles", gap_a, e.gap);
                    if (e.chk_i) chk("a_instr", iv_a, e.instr);
                    chk("a_load_data", dinv_a, e.data);
                end
                gap_a = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!nreset_b) begin
            gap_b = 0;
        end else begin
            gap_b++;
            if (ce_b) begin
                if (qb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected_clk_en actual=1 required=0");
                end else begin
                    e = qb.pop_front();
                    chk("b_step_cycles", gap_b, e.gap);
                    if (e.chk_i) chk("b_instr", iv_b, e.instr);
                    chk("b_load_data", dinv_b, e.data);
                end
                gap_b = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        nreset_a = 1'b0; ien_a = 1'b0; ia_a = '0; da_a = '0; dv_a = '0; rd_a = 1'b0; wr_a = 1'b0;
        nreset_b = 1'b0; ien_b = 1'b0; ia_b = '0; da_b = '0; dv_b = '0; rd_b = 1'b0; wr_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Seed instance a: word 0 = 0x12345678, word 0x80 = 0x1.
        drive(0, 32'h0, 32'h0, 32'h1234_5678, 1'b0, 1'b1);
        push_exp(0, 0, 32'h0, 32'h0, 7);
        nreset_a = 1'b1;
        wait_step(0);
        drive(0, 32'h0, 32'h80, 32'h0000_0001, 1'b0, 1'b1);
        push_exp(0, 1, 32'h1234_5678, 32'h0, 7);
        wait_step(0);

        nreset_a = 1'b0;
        @(negedge clk);
        chk_reset_a("a_reset1");
        @(posedge clk);
        #1;

        // Fetch-only step straight out of reset: clk_en in the 5th cycle.
        drive(0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        push_exp(0, 1, 32'h1234_5678, 32'h0, 5);
        nreset_a = 1'b1;
        wait_step(0);
        drive(0, 32'h0, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1);
        push_exp(0, 1, 32'h1234_5678, 32'h0, 7);
        wait_step(0);
        drive(0, 32'h0, 32'h40, 32'h0, 1'b1, 1'b0);
        push_exp(0, 1, 32'h1234_5678, 32'hDEAD_BEEF, 7);
        wait_step(0);
        drive(0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
        push_exp(0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5);
        wait_step(0);
        drive(0, 32'h3, 32'h83, 32'h0, 1'b1, 1'b0);
        push_exp(0, 1, 32'h1234_5678, 32'h0000_0001, 7);
        wait_step(0);

        // Store to 0x80 aborted by reset in the first DATA cycle.
        drive(0, 32'h0, 32'h80, 32'hCAFE_F00D, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        nreset_a = 1'b0;
        @(negedge clk);
        chk_reset_a("a_reset_abort");
        @(posedge clk);
        #1;
        drive(0, 32'h0, 32'h80, 32'h0, 1'b1, 1'b0);
        push_exp(0, 1, 32'h1234_5678, 32'h0000_0001, 7);
        nreset_a = 1'b1;
        wait_step(0);

        // read and write together in DECODE.
        drive(0, 32'h0, 32'h80, 32'h0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("a_rw_fault_in_decode", {31'h0, mf_a}, 32'h0);
        @(negedge clk);
        chk("a_rw_fault", {31'h0, mf_a}, 32'h1);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (ce_a) n++;
        end
        chk("a_fault_clk_en_count", n, 0);
        chk("a_fault_sticky", {31'h0, mf_a}, 32'h1);
        @(posedge clk);
        #1;
        nreset_a = 1'b0;
        @(negedge clk);
        chk_reset_a("a_reset_rw_fault");
        @(posedge clk);
        #1;

        // Out-of-range fetch faults at the end of FETCH.
        drive(0, 32'h0000_1000, 32'h0, 32'h0, 1'b0, 1'b0);
        nreset_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("a_oor_fetch_in_fetch", {31'h0, mf_a}, 32'h0);
        @(negedge clk);
        chk("a_oor_fetch_fault", {31'h0, mf_a}, 32'h1);
        chk("a_oor_fetch_clk_en", {31'h0, ce_a}, 32'h0);
        @(posedge clk);
        #1;
        nreset_a = 1'b0;
        @(negedge clk);
        chk_reset_a("a_reset_oor_fetch");
        @(posedge clk);
        #1;

        // Out-of-range data address faults at the end of DECODE.
        drive(0, 32'h0, 32'h0000_2000, 32'h0, 1'b1, 1'b0);
        nreset_a = 1'b1;
        repeat (4) @(negedge clk);
        chk("a_oor_data_in_decode", {31'h0, mf_a}, 32'h0);
        @(negedge clk);
        chk("a_oor_data_fault", {31'h0, mf_a}, 32'h1);
        @(posedge clk);
        #1;
        nreset_a = 1'b0;
        @(posedge clk);
        #1;

        drive(0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        push_exp(0, 1, 32'h1234_5678, 32'h0, 5);
        nreset_a = 1'b1;
        wait_step(0);
        ien_a = 1'b0;

        // Instance b, WAIT=0: fetch-only steps every 4 cycles.
        drive(1, 32'h0, 32'h0, 32'hFACE_0001, 1'b0, 1'b1);
        push_exp(1, 0, 32'h0, 32'h0, 5);
        nreset_b = 1'b1;
        wait_step(1);
        for (int s = 0; s < 3; s++) begin
            drive(1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
            push_exp(1, 1, 32'hFACE_0001, 32'h0, 4);
            wait_step(1);
        end
        drive(1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        push_exp(1, 1, 32'hFACE_0001, 32'hFACE_0001, 5);
        wait_step(1);
        ien_b = 1'b0;

        repeat (10) @(posedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the CPU's instruction and data memory ports. It holds a single-port word array and serves one instruction fetch plus at most one data access per CPU step. It paces the core by driving `clk_en`, which it pulses high for exactly one cycle when the step's results are ready. It sits between the CPU and the bench/top level, replacing ideal zero-latency memory with a configurable wait-state model.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width; array depth is 2^ADDR_W words.
- `WAIT`, default 1: extra wait cycles per array access; legal range 0..15.

Ports:
- `clk`, input, 1: the single clock.
- `nreset`, input, 1: asynchronous active-low reset.
- `instruction_memory_a`, input, 32: fetch byte address.
- `instruction_memory_en`, input, 1: fetch enable.
- `data_memory_a`, input, 32: data byte address.
- `data_memory_out_v`, input, 32: CPU store data.
- `data_memory_read`, input, 1: load request.
- `data_memory_write`, input, 1: store request.
- `instruction_memory_v`, output, 32: fetched instruction (registered).
- `data_memory_in_v`, output, 32: load result (registered).
- `clk_en`, output, 1: CPU step enable.
- `mem_fault`, output, 1: sticky fault flag.

## Operation
- Word index is `addr[ADDR_W+1:2]`; bits [1:0] are ignored. Any set bit in [31:ADDR_W+2] is out of range.
- FSM states: IDLE, FETCH, DECODE, DATA, RELEASE, FAULT.
- IDLE: with `instruction_memory_en`=1, latch the fetch address and go to FETCH with the wait counter loaded with `WAIT`. Otherwise stay in IDLE.
- FETCH: the counter decrements each cycle. When it reaches 0, register `array[idx]` into `instruction_memory_v` and go to DECODE. An out-of-range fetch goes to FAULT instead.
- DECODE: one settle cycle so the CPU decodes the new instruction combinationally. At the end of the cycle, sample the data controls, address and store data.
  - read=write=1 -> FAULT.
  - Out-of-range address with read or write -> FAULT.
  - read or write alone -> DATA, counter loaded with `WAIT`.
  - Neither -> RELEASE.
- DATA: when the counter reaches 0, perform the access. A store writes `array[idx]`; `data_memory_in_v` keeps its previous value. A load registers `array[idx]` into `data_memory_in_v`. Then go to RELEASE.
- RELEASE: `clk_en`=1 for this cycle only, so the CPU commits on the next rising edge. Then go to IDLE.
- FAULT: `mem_fault`=1, `clk_en`=0, no array writes. The state is terminal until reset.
- `clk_en` is 1 only in RELEASE.
- Reset values: state IDLE; `clk_en`=0; `mem_fault`=0; `instruction_memory_v`=0; `data_memory_in_v`=0; wait counter 0.
- Array contents are not reset.
- Reset asserted mid-access aborts that access immediately. A store whose DATA completion edge has not occurred is not written.

## Timing
- Step without data access: 1 (IDLE) + `WAIT`+1 (FETCH) + 1 (DECODE) + 1 (RELEASE) = `WAIT`+4 cycles.
- Step with data access: 2·`WAIT`+5 cycles.
- `instruction_memory_v` is stable from DECODE through RELEASE inclusive.
- `data_memory_in_v` is stable during RELEASE.
- Inputs are sampled only at:
  - the IDLE exit edge: fetch address;
  - the DECODE exit edge: data side.
- Changes at other times are ignored.
- `clk_en` never stays high on two consecutive cycles.

## Configuration
- `CPU_MEM_LOAD_EN` defined: adds the ports below.
  - `load_en`, input, 1
  - `load_a`, input, ADDR_W
  - `load_v`, input, 32
  - While the FSM is in IDLE, `load_en`=1 writes `array[load_a]` = `load_v` and blocks leaving IDLE for that cycle.
  - `load_en` is ignored in all other states.
- Macro undefined: the ports are absent and the array is initialised only by simulation means.

## Structure
- Shared package `cpu_mem_pkg`:
  - state enum (6 states);
  - `WAIT_W`=4 wait-counter width;
  - out-of-range check constant/function.
- Sub-module `cpu_mem_array`: single-port synchronous word RAM (`ADDR_W`×32). Write-enable plus address in; registered read out. It is the only holder of array storage.
- FSM, wait counter, fault logic and output registers live in the top module.

## Test plan
- `WAIT`=1; preload word 0 = 0x12345678; release reset with `instruction_memory_en`=1, addr 0x0 -> `clk_en` first high in the 5th cycle after leaving reset, with `instruction_memory_v`=0x12345678.
- Store 0xDEADBEEF to 0x40, then in the next step load 0x40 -> store step lasts 7 cycles; the load step gives `data_memory_in_v`=0xDEADBEEF during RELEASE.
- `WAIT`=0 -> fetch-only steps are 4 cycles apart. `clk_en` high pattern is 0001 repeating, never two consecutive highs.
- `data_memory_read`=`data_memory_write`=1 in DECODE -> `mem_fault`=1 next cycle, and `clk_en` stays 0 for 20 further cycles.
- Fetch address 0x0000_1000 with `ADDR_W`=10 -> FAULT from FETCH. Then pulse `nreset` low -> `mem_fault`=0, `clk_en`=0, outputs 0.
- Assert `nreset` low during DATA of a store to 0x80 (old value 0x1) -> after reset, a load of 0x80 returns 0x1.
